// File: rtl/knn_distance_sequencer.sv
// rtl/knn_distance_sequencer.sv - nearest-neighbour scan controller: fetch, launch, wait, compare per entry.
// Optional build macro KNN_EARLY_EXIT_EN: stop the scan as soon as a zero distance is seen.
module knn_distance_sequencer #(
  parameter int NUM_SAMPLES = 16,
  parameter int ADDR_W      = 4,
  parameter int DIST_W      = 48,
  parameter int LABEL_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W:0]    num_samples,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [LABEL_W-1:0] mem_label,
  output logic               calc_start,
  input  logic               calc_done,
  input  logic [DIST_W-1:0]  calc_distance,
  output logic               result_valid,
  output logic [ADDR_W-1:0]  best_index,
  output logic [DIST_W-1:0]  best_distance,
  output logic [LABEL_W-1:0] best_label
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAUNCH,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(NUM_SAMPLES);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

  state_t              state;
  logic [ADDR_W-1:0]   index;
  logic [ADDR_W:0]     count;
  logic [LABEL_W-1:0]  cur_label;
  logic [DIST_W-1:0]   cur_distance;

  logic [ADDR_W:0]     num_clamped;
  logic                last_entry;
  logic                finish_scan;
  logic [ADDR_W-1:0]   next_index;

  always_comb begin
    num_clamped = (num_samples > MAX_COUNT) ? MAX_COUNT : num_samples;
    last_entry  = ({1'b0, index} == (count - ONE));
    next_index  = index + 1'b1;
`ifdef KNN_EARLY_EXIT_EN
    // An exact match cannot be beaten, so the remaining entries are skipped.
    finish_scan = last_entry || (cur_distance == '0);
`else
    finish_scan = last_entry;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      index         <= '0;
      count         <= '0;
      cur_label     <= '0;
      cur_distance  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_addr      <= '0;
      calc_start    <= 1'b0;
      result_valid  <= 1'b0;
      best_index    <= '0;
      best_distance <= '1;
      best_label    <= '0;
    end else begin
      done       <= 1'b0;
      mem_rd_en  <= 1'b0;
      calc_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            count         <= num_clamped;
            index         <= '0;
            best_distance <= '1;
            result_valid  <= 1'b0;
            busy          <= 1'b1;
            if (num_clamped != '0) begin
              state     <= S_FETCH;
              mem_rd_en <= 1'b1;
              mem_addr  <= '0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          state      <= S_LAUNCH;
          calc_start <= 1'b1;
        end
        S_LAUNCH: begin
          // Memory read latency is one cycle, so the label lands here.
          cur_label <= mem_label;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (calc_done) begin
            cur_distance <= calc_distance;
            state        <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          // Strict compare: on a tie the earlier (lower) index is kept.
          if (cur_distance < best_distance) begin
            best_distance <= cur_distance;
            best_index    <= index;
            best_label    <= cur_label;
          end
          if (finish_scan) begin
            state        <= S_DONE;
            done         <= 1'b1;
            result_valid <= 1'b1;
          end else begin
            index     <= next_index;
            state     <= S_FETCH;
            mem_rd_en <= 1'b1;
            mem_addr  <= next_index;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_distance_sequencer.sv
// tb/tb_knn_distance_sequencer.sv - directed bench with memory/calculator responders and a nearest-neighbour model.
module tb_knn_distance_sequencer;
  localparam int NS = 16;
  localparam int AW = 4;
  localparam int DW = 48;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_samples = '0;
  logic          busy, done, mem_rd_en, calc_start, result_valid;
  logic [AW-1:0] mem_addr, best_index;
  logic [LW-1:0] mem_label = '0;
  logic          calc_done = 1'b0;
  logic [DW-1:0] calc_distance = '0;
  logic [DW-1:0] best_distance;
  logic [LW-1:0] best_label;

  knn_distance_sequencer #(.NUM_SAMPLES(NS), .ADDR_W(AW), .DIST_W(DW), .LABEL_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_label(mem_label), .calc_start(calc_start), .calc_done(calc_done),
    .calc_distance(calc_distance), .result_valid(result_valid),
    .best_index(best_index), .best_distance(best_distance), .best_label(best_label)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [DW-1:0] dists [NS];
  logic [LW-1:0] labels[NS];
  int            lat = 1;
  bit            spurious_en = 0;

  // Training memory and distance calculator models, driven mid-cycle.
  int            pending = 0;
  bit            lbl_pend = 0;
  logic [AW-1:0] rd_addr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 0; lbl_pend = 0; calc_done = 1'b0; mem_label = '0;
    end else begin
      calc_done = 1'b0;
      if (lbl_pend) begin mem_label = labels[rd_addr]; lbl_pend = 0; end
      else mem_label = '0;
      if (mem_rd_en) begin
        rd_addr = mem_addr; lbl_pend = 1;
        if (spurious_en) begin calc_done = 1'b1; calc_distance = '0; end
      end
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin calc_done = 1'b1; calc_distance = dists[rd_addr]; end
      end
      if (calc_start) pending = lat;
    end
  end

  // Reference model: plain minimum search over the entries that must be scanned.
  int            exp_scan, exp_cycles;
  bit            exp_valid;
  int            exp_idx;
  logic [DW-1:0] exp_dist;
  logic [LW-1:0] exp_label;

  task automatic compute_expect(input int n_in);
    int n;
    n = (n_in > NS) ? NS : n_in;
    exp_valid = (n != 0);
    exp_scan = n;
`ifdef KNN_EARLY_EXIT_EN
    for (int i = 0; i < n; i++)
      if (dists[i] == 0) begin exp_scan = i + 1; break; end
`endif
    exp_dist = '1; exp_idx = 0; exp_label = '0;
    for (int i = 0; i < exp_scan; i++)
      if (dists[i] < exp_dist) begin exp_dist = dists[i]; exp_idx = i; exp_label = labels[i]; end
    exp_cycles = (exp_scan == 0) ? 1 : (3 + lat) * exp_scan + 1;
  endtask

  bit active = 0;
  bit seen_done = 0;
  int cyc, rd_cnt, cs_cnt, last_cycles, last_cs;

  always @(negedge clk) begin
    if (active) begin
      cyc++;
      check("busy_during_search", busy, 1);
      if (mem_rd_en) begin check("mem_addr_seq", mem_addr, rd_cnt); rd_cnt++; end
      if (calc_start) cs_cnt++;
      if (done) begin
        check("done_latency", cyc, exp_cycles);
        check("calc_start_pulses", cs_cnt, exp_scan);
        check("mem_rd_pulses", rd_cnt, exp_scan);
        check("result_valid", result_valid, exp_valid);
        check("best_distance", best_distance, exp_dist);
        if (exp_valid) begin
          check("best_index", best_index, exp_idx);
          check("best_label", best_label, exp_label);
        end
        last_cycles = cyc; last_cs = cs_cnt;
        active = 0; seen_done = 1;
      end
    end
  end

  task automatic run_search(input int n_in, input int restart_at);
    compute_expect(n_in);
    @(negedge clk);
    start = 1'b1; num_samples = n_in[AW:0];
    @(posedge clk);
    cyc = 0; rd_cnt = 0; cs_cnt = 0; seen_done = 0; active = 1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3000 && !seen_done; k++) begin
      @(negedge clk);
      if (restart_at > 0 && k == restart_at) begin start = 1'b1; num_samples = 5'd1; end
      else start = 1'b0;
    end
    start = 1'b0;
    if (!seen_done) begin check("done_timeout", 0, 1); active = 0; end
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin dists[i] = 48'd9999; labels[i] = LW'((i * 7 + 3) % 16); end
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_calc_start", calc_start, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_best_index", best_index, 0);
    check("rst_best_label", best_label, 0);
    check("rst_best_distance", best_distance, 48'hFFFF_FFFF_FFFF);
    rst_n = 1'b1;

    // Three entries, latency 1
    lat = 1;
    dists[0] = 500; dists[1] = 120; dists[2] = 300;
    run_search(3, 0);
    check("t1_cycles_lit", last_cycles, 13);
    check("t1_index_lit", best_index, 1);
    check("t1_dist_lit", best_distance, 120);
    check("t1_label_lit", best_label, 10);
    check("t1_valid_lit", result_valid, 1);

    // Ties keep the lowest index
    dists[0] = 80; dists[1] = 80; dists[2] = 200; dists[3] = 80;
    run_search(4, 0);
    check("t2_index_lit", best_index, 0);
    check("t2_pulses_lit", last_cs, 4);

    // Empty scan
    run_search(0, 0);
    check("t3_cycles_lit", last_cycles, 1);
    check("t3_valid_lit", result_valid, 0);
    check("t3_dist_lit", best_distance, 48'hFFFF_FFFF_FFFF);
    check("t3_pulses_lit", last_cs, 0);

    // Slow calculator, spurious calc_done in FETCH, start re-pulsed while busy
    lat = 7; spurious_en = 1;
    dists[0] = 900; dists[1] = 45; dists[2] = 77; dists[3] = 45; dists[4] = 1000;
    run_search(5, 3);
    spurious_en = 0;
    check("t4_index_lit", best_index, 1);
    check("t4_dist_lit", best_distance, 45);
    check("t4_cycles_lit", last_cycles, 51);

    // Reset in WAIT of the third entry, then a clean search
    begin
      int seen_cs;
      seen_cs = 0;
      @(negedge clk); start = 1'b1; num_samples = 5'd5;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 500 && seen_cs < 3; k++) begin
        @(negedge clk);
        if (calc_start) seen_cs++;
      end
      check("t5_reached_third", seen_cs, 3);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_valid", result_valid, 0);
      check("t5_rst_dist", best_distance, 48'hFFFF_FFFF_FFFF);
      check("t5_rst_index", best_index, 0);
      check("t5_rst_rd_en", mem_rd_en, 0);
      rst_n = 1'b1;
      lat = 2;
      dists[5] = 30;
      run_search(6, 0);
      check("t5_index_lit", best_index, 5);
    end

    // Zero distance in entry 2 of 8
    lat = 1;
    for (int i = 0; i < 8; i++) dists[i] = 48'(100 + i);
    dists[2] = 0; dists[6] = 0;
    run_search(8, 0);
    check("t6_index_lit", best_index, 2);
    check("t6_dist_lit", best_distance, 0);

    // Oversized count is clamped to the memory depth
    for (int i = 0; i < NS; i++) dists[i] = 48'(1000 - i * 10);
    run_search(20, 0);
    check("t7_index_lit", best_index, 15);
    check("t7_pulses_lit", last_cs, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
